// File: rtl/ddr_wr_burst_master.sv
// ddr_wr_burst_master: drains 256-bit words from the write FIFO and issues
// fixed-length AXI4 INCR write bursts over a linear, wrapping frame buffer.
// Optional build macro DDR_WR_ERR_CNT_EN enables the error-response counter;
// without it err_cnt is tied to zero.
module ddr_wr_burst_master #(
   parameter int                    ADDR_WIDTH  = 28,
   parameter int                    DATA_WIDTH  = 256,
   parameter int                    LVL_WIDTH   = 10,
   parameter int                    BURST_LEN   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    FRAME_BYTES = 1920*1080*2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic [LVL_WIDTH-1:0]  fifo_rd_water_level,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic [7:0]            m_awlen,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   output logic                  m_wlast,
   input  logic                  m_bvalid,
   input  logic [1:0]            m_bresp,
   output logic                  m_bready,
   output logic                  busy,
   output logic [15:0]           err_cnt
);

   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 32);
   localparam logic [ADDR_WIDTH-1:0] FRAME_SIZE  = ADDR_WIDTH'(FRAME_BYTES);
   localparam logic [8:0]            BURST_CNT   = 9'(BURST_LEN);
   localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   offset, offset_eff, offset_inc, awaddr_q;
   logic                    fs_latch;
   logic [8:0]              rd_cnt, beat_cnt;
   logic [DATA_WIDTH-1:0]   buf0, buf1;
   logic [1:0]              occ;
   logic                    rd_inflight, pop, last_beat, lvl_ok;
   logic [2:0]              slots;

   // A pending or same-cycle frame_start restarts the frame at BASE_ADDR.
   assign offset_eff = (fs_latch | frame_start) ? '0 : offset;
   assign offset_inc = offset + BURST_BYTES;
   assign lvl_ok     = fifo_rd_water_level >= LVL_WIDTH'(BURST_LEN);
   assign pop        = m_wvalid & m_wready;
   assign last_beat  = pop & (beat_cnt == LAST_BEAT);
   // Skid slots committed after this cycle; counting the slot freed by an
   // accepted beat keeps reads flowing at one word per cycle.
   assign slots      = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_inflight};

   assign m_awlen  = 8'(BURST_LEN - 1);
   assign m_awaddr = awaddr_q;
   assign m_wvalid = occ != 2'd0;
   assign m_wdata  = buf0;
   assign m_wlast  = m_wvalid & (beat_cnt == LAST_BEAT);
   assign busy     = state != IDLE;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt  = state;
      m_awvalid  = 1'b0;
      m_bready   = 1'b0;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE: if (lvl_ok) state_nxt = ADDR;
         ADDR: begin
            m_awvalid = 1'b1;
            if (m_awready) state_nxt = DATA;
         end
         DATA: begin
            fifo_rd_en = (rd_cnt < BURST_CNT) && (slots < 3'd2);
            if (last_beat) state_nxt = RESP;
         end
         RESP: begin
            m_bready = 1'b1;
            if (m_bvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame offset, frame_start latch and burst address load.
   always_ff @(posedge clk) begin
      if (rst) begin
         offset   <= '0;
         fs_latch <= 1'b0;
         awaddr_q <= BASE_ADDR;
      end else if (state == IDLE) begin
         offset   <= offset_eff;
         fs_latch <= 1'b0;
         if (lvl_ok) awaddr_q <= BASE_ADDR + offset_eff;
      end else begin
         if (frame_start) fs_latch <= 1'b1;
         if (state == RESP && m_bvalid)
            offset <= (offset_inc == FRAME_SIZE) ? '0 : offset_inc;
      end
   end

   // Per-burst read-issue and accepted-beat counters.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) begin
         rd_cnt   <= '0;
         beat_cnt <= '0;
      end else begin
         if (fifo_rd_en) rd_cnt   <= rd_cnt + 9'd1;
         if (pop)        beat_cnt <= beat_cnt + 9'd1;
      end
   end

   // Two-entry skid buffer; buf0 is the W-channel head.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_inflight <= 1'b0;
         occ         <= '0;
         buf0        <= '0;
         buf1        <= '0;
      end else begin
         rd_inflight <= fifo_rd_en;
         case ({rd_inflight, pop})
            2'b10: begin
               if (occ == 2'd0) buf0 <= fifo_rd_data;
               else             buf1 <= fifo_rd_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf0 <= buf1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) buf0 <= fifo_rd_data;
               else begin
                  buf0 <= buf1;
                  buf1 <= fifo_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DDR_WR_ERR_CNT_EN
   logic [15:0] err_q;

   // Saturating count of non-OKAY write responses.
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= '0;
      else if (m_bvalid && m_bready && m_bresp != 2'b00 && err_q != 16'hFFFF)
         err_q <= err_q + 16'd1;
   end

   assign err_cnt = err_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^m_bresp;
   assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Bench for ddr_wr_burst_master: FIFO + AXI slave model with a per-cycle
// checker, driven by a directed burst sequence (threshold, streaming,
// backpressure, wrap, frame_start, error responses, mid-burst reset).
module tb_ddr_wr_burst_master;
   localparam int AW = 28, DW = 256, LW = 10, BL = 16;
   localparam int FRAME = 3 * 512;
`ifdef DDR_WR_ERR_CNT_EN
   localparam int EXP_ERR = 3;
`else
   localparam int EXP_ERR = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic [LW-1:0] fifo_rd_water_level;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic [AW-1:0] m_awaddr;
   logic [7:0]    m_awlen;
   logic          m_awvalid;
   logic          m_awready = 1'b1;
   logic [DW-1:0] m_wdata;
   logic          m_wvalid;
   logic          m_wready = 1'b1;
   logic          m_wlast;
   logic          m_bvalid = 1'b0;
   logic [1:0]    m_bresp = 2'b00;
   logic          m_bready;
   logic          busy;
   logic [15:0]   err_cnt;

   always #5 clk = ~clk;

   ddr_wr_burst_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LVL_WIDTH(LW), .BURST_LEN(BL),
      .BASE_ADDR('0), .FRAME_BYTES(FRAME)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
      .busy(busy), .err_cnt(err_cnt)
   );

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Word i of the FIFO stream: eight distinct lanes tagged with the index.
   function automatic logic [DW-1:0] pat(input int i);
      logic [DW-1:0] r;
      for (int j = 0; j < 8; j++) r[32*j +: 32] = 32'hC000_0000 | (32'(i) << 8) | 32'(j);
      return r;
   endfunction

   // Stimulus controls (written by the initial block only).
   int pushed = 0;
   int wready_mode = 0;       // 0: always ready, 1: toggle every cycle
   logic [1:0] bresp_val = 2'b00;

   // Model state (written by the model process only).
   int popped = 0, rd_word = 0, bursts_done = 0, beat_idx = 0, cyc = 0;
   int beat_in_burst = 0, reads_in_burst = 0, exp_off = 0;
   int first_rd = -1, first_wv = -1, first_beat = 0, last_beat_c = 0;
   bit fs_pending = 0, fast = 0, rd_prev = 0, last_prev = 0, b_hs_prev = 0;
   bit prev_awv = 0, prev_wv = 0, prev_wr = 0, prev_wlast = 0;
   logic [DW-1:0] prev_wdata = '0;
   int aw_log[$];

   assign fifo_rd_water_level = LW'(pushed - popped);

   // FIFO + AXI slave model and per-cycle checker, sampled mid-cycle.
   always @(negedge clk) begin
      if (rd_prev) fifo_rd_data = pat(rd_word);
      m_wready = (wready_mode == 0) ? 1'b1 : ~m_wready;
      if (b_hs_prev) m_bvalid = 1'b0;
      b_hs_prev = 0;
      if (last_prev) begin m_bvalid = 1'b1; m_bresp = bresp_val; end
      last_prev = 0;
      #1;
      cyc++;
      if (rst) begin
         m_bvalid = 1'b0; rd_prev = 0; exp_off = 0; fs_pending = 0;
         beat_in_burst = 0; reads_in_burst = 0; beat_idx = popped;
         prev_awv = 0; prev_wv = 0; prev_wr = 0;
      end else begin
         if (m_awvalid && !prev_awv) begin
            if (fs_pending) begin exp_off = 0; fs_pending = 0; end
            chk("awaddr", 32'(m_awaddr), 32'(exp_off));
            aw_log.push_back(int'(m_awaddr));
            reads_in_burst = 0; beat_in_burst = 0; first_rd = -1; first_wv = -1;
            fast = (wready_mode == 0);
         end
         if (m_awvalid && m_awready) chk("awlen", 32'(m_awlen), 32'(BL - 1));
         if (frame_start) fs_pending = 1;
         if (m_awvalid || m_wvalid || m_bready) chk("busy", 32'(busy), 32'd1);
         if (fifo_rd_en) begin
            chk("rd_only_in_burst", 32'(busy && !m_bready), 32'd1);
            chk("fifo_not_empty", 32'(pushed - popped > 0), 32'd1);
            if (first_rd < 0) first_rd = cyc;
            rd_word = popped; popped++; reads_in_burst++;
         end
         rd_prev = fifo_rd_en;
         if (m_wvalid && first_wv < 0) first_wv = cyc;
         if (prev_wv && !prev_wr) begin
            chk("stall_wvalid", 32'(m_wvalid), 32'd1);
            chk_data("stall_wdata", m_wdata, prev_wdata);
            chk("stall_wlast", 32'(m_wlast), 32'(prev_wlast));
         end
         if (m_wvalid && m_wready) begin
            chk_data("wdata", m_wdata, pat(beat_idx));
            chk("wlast", 32'(m_wlast), 32'(beat_in_burst == BL - 1));
            if (beat_in_burst == 0) first_beat = cyc;
            if (beat_in_burst == BL - 1) begin last_beat_c = cyc; last_prev = 1; end
            beat_idx++; beat_in_burst++;
         end
         if (m_bvalid && m_bready) begin
            chk("reads_per_burst", 32'(reads_in_burst), 32'(BL));
            chk("beats_per_burst", 32'(beat_in_burst), 32'(BL));
            if (fast) begin
               chk("first_wvalid_lat", 32'(first_wv - first_rd), 32'd2);
               chk("zero_bubble", 32'(last_beat_c - first_beat), 32'(BL - 1));
            end
            exp_off = (exp_off + BL * 32) % FRAME;
            bursts_done++;
            b_hs_prev = 1;
         end
         prev_awv = m_awvalid; prev_wv = m_wvalid; prev_wr = m_wready;
         prev_wdata = m_wdata; prev_wlast = m_wlast;
      end
   end

   task automatic reset_checks(input string tag);
      chk({tag, "_awvalid"}, 32'(m_awvalid), 32'd0);
      chk({tag, "_awaddr"}, 32'(m_awaddr), 32'd0);
      chk({tag, "_awlen"}, 32'(m_awlen), 32'd15);
      chk({tag, "_wvalid"}, 32'(m_wvalid), 32'd0);
      chk({tag, "_wlast"}, 32'(m_wlast), 32'd0);
      chk_data({tag, "_wdata"}, m_wdata, '0);
      chk({tag, "_bready"}, 32'(m_bready), 32'd0);
      chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   task automatic wait_bursts(input int n);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #2;
         if (bursts_done >= n) return;
      end
      chk("burst_timeout", 32'(bursts_done), 32'(n));
   endtask

   task automatic wait_wvalid();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #2;
         if (m_wvalid) return;
      end
      chk("wvalid_timeout", 32'(m_wvalid), 32'd1);
   endtask

   int exp_aw[8] = '{'h000, 'h200, 'h400, 'h000, 'h200, 'h000, 'h200, 'h000};

   initial begin
      repeat (3) @(negedge clk);
      #2 reset_checks("rst0");
      @(negedge clk) rst = 1'b0;

      // Level threshold: 15 words must not start a burst, 16 must.
      pushed = 15;
      repeat (6) begin @(negedge clk); #2 chk("no_aw_at_15", 32'(m_awvalid), 32'd0); end
      @(negedge clk) pushed = 16;
      @(negedge clk); #2;
      chk("aw_at_16_valid", 32'(m_awvalid), 32'd1);
      chk("aw_at_16_addr", 32'(m_awaddr), 32'h0);
      chk("aw_at_16_len", 32'(m_awlen), 32'd15);
      wait_bursts(1);

      // Backpressure burst, then full-speed bursts through the frame wrap.
      @(negedge clk) begin wready_mode = 1; pushed += 16; end
      wait_bursts(2);
      @(negedge clk) begin wready_mode = 0; pushed += 16; end
      wait_bursts(3);
      @(negedge clk) begin bresp_val = 2'b10; pushed += 16; end
      wait_bursts(4);

      // frame_start during DATA of the 0x200 burst.
      @(negedge clk) pushed += 16;
      wait_wvalid();
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
      wait_bursts(5);
      @(negedge clk) pushed += 16;
      wait_bursts(6);
      @(negedge clk) bresp_val = 2'b00;
      @(negedge clk); #2 chk("err_cnt", 32'(err_cnt), 32'(EXP_ERR));

      // Reset in the middle of DATA aborts the burst and the FIFO.
      @(negedge clk) pushed += 16;
      wait_wvalid();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      pushed = popped;
      @(negedge clk); #2 reset_checks("rst_mid");
      @(negedge clk) rst = 1'b0;
      @(negedge clk) pushed += 16;
      wait_bursts(7);
      repeat (4) @(negedge clk);

      chk("aw_count", 32'(aw_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < aw_log.size(); i++)
         chk($sformatf("aw_seq_%0d", i), 32'(aw_log[i]), 32'(exp_aw[i]));
      chk("all_words_read", 32'(popped), 32'(pushed));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
